// File: rtl/bus_arb_ctrl_if.sv
// rtl/bus_arb_ctrl_if.sv - master/arbiter handshake bundle for the shared system bus arbiter
//
// Purpose: groups the request/grant/completion signals between the bus masters,
//          the selected slave and bus_arb_ctrl.
// Signals:
//   m_req_i        [2:0] per-master request (0=ex, 1=if, 2=jtag)
//   s_ack_i              selected slave completes the current transfer
//   grant_o        [1:0] granted master index, drives the bus mux select
//   grant_valid_o        grant_o owns the bus this cycle
//   m_ack_o        [2:0] one-cycle completion pulse to the granted master
//   m_err_o        [2:0] one-cycle timeout-abort pulse to the granted master
//   hold_flag_o          pipeline hold flag
//   busy_o               arbiter is in its BUSY state
// Modports: slave = arbiter side, master = requester/slave-model side.
interface bus_arb_ctrl_if;
  logic [2:0] m_req_i;
  logic       s_ack_i;
  logic [1:0] grant_o;
  logic       grant_valid_o;
  logic [2:0] m_ack_o;
  logic [2:0] m_err_o;
  logic       hold_flag_o;
  logic       busy_o;

  modport slave (
    input  m_req_i,
    input  s_ack_i,
    output grant_o,
    output grant_valid_o,
    output m_ack_o,
    output m_err_o,
    output hold_flag_o,
    output busy_o
  );

  modport master (
    output m_req_i,
    output s_ack_i,
    input  grant_o,
    input  grant_valid_o,
    input  m_ack_o,
    input  m_err_o,
    input  hold_flag_o,
    input  busy_o
  );
endinterface

// File: rtl/bus_arb_ctrl.sv
// rtl/bus_arb_ctrl.sv - registered bus arbiter with grant lock, aging and completion timeout
//
// Purpose: picks one of three masters, locks grant_o from grant until slave
//          completion (or abort), promotes starved masters and aborts stalled
//          transfers.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   bus   bus_arb_ctrl_if.slave: m_req_i, s_ack_i in; grant_o, grant_valid_o,
//         m_ack_o, m_err_o, hold_flag_o, busy_o out
module bus_arb_ctrl #(
  parameter int STARVE_LIMIT   = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic           clk,
  input  logic           rst,
  bus_arb_ctrl_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic [CNT_W-1:0]        tmo_q, tmo_d;
  logic [2:0][CNT_W-1:0]   age_q, age_d;

  logic [2:0] req;
  logic [2:0] aged;
  logic [2:0] grant_oh;
  logic [2:0] others;
  logic [2:0] ack;
  logic [2:0] err;
  logic       new_grant;
  logic       end_tenure;
  logic       grant_valid;

  // Aged masters win first (lowest index), otherwise fixed 0 > 2 > 1.
  // Callers only use the result when elig is non-zero.
  function automatic logic [1:0] pick(input logic [2:0] elig, input logic [2:0] aged_v);
    logic [2:0] a;
    a = elig & aged_v;
    if (a[0])         pick = 2'd0;
    else if (a[1])    pick = 2'd1;
    else if (a[2])    pick = 2'd2;
    else if (elig[0]) pick = 2'd0;
    else if (elig[2]) pick = 2'd2;
    else              pick = 2'd1;
  endfunction

  assign req         = bus.m_req_i;
  assign grant_valid = (state_q == S_BUSY);
  assign grant_oh    = 3'b001 << grant_q;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      aged[n] = (age_q[n] == STARVE_C);
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    tmo_d      = tmo_q;
    ack        = 3'b000;
    err        = 3'b000;
    new_grant  = 1'b0;
    end_tenure = 1'b0;
    others     = req & ~grant_oh;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          new_grant = 1'b1;
          grant_d   = pick(req, aged);
          state_d   = S_BUSY;
          tmo_d     = '0;
        end
      end
      S_BUSY: begin
        if (bus.s_ack_i) begin
          ack        = grant_oh;
          end_tenure = 1'b1;
        end else if (!req[grant_q]) begin
          // Master withdrew before completion: silent abort.
          state_d = S_IDLE;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          err        = grant_oh;
          end_tenure = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + CNT_W'(1);
        end

        // Re-arbitrate in the completing cycle so the bus never idles
        // between back-to-back tenures; the finishing master only
        // re-wins when nobody else is asking.
        if (end_tenure) begin
          if (|others) begin
            new_grant = 1'b1;
            grant_d   = pick(others, aged);
            tmo_d     = '0;
          end else if (req[grant_q]) begin
            new_grant = 1'b1;
            tmo_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Age counts denied cycles of a pending request; the current owner's
  // count is frozen, a fresh grant or a dropped request clears it.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      age_d[n] = age_q[n];
      if (!req[n]) begin
        age_d[n] = '0;
      end else if (new_grant && (grant_d == 2'(n))) begin
        age_d[n] = '0;
      end else if (grant_valid && (grant_q == 2'(n))) begin
        age_d[n] = age_q[n];
      end else if (age_q[n] != STARVE_C) begin
        age_d[n] = age_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'h1;
      tmo_q   <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tmo_q   <= tmo_d;
      age_q   <= age_d;
    end
  end

  assign bus.grant_o       = grant_q;
  assign bus.grant_valid_o = grant_valid;
  assign bus.busy_o        = grant_valid;
  assign bus.m_ack_o       = ack;
  assign bus.m_err_o       = err;
  // Gated by rst so requests seen during reset do not raise the hold.
  assign bus.hold_flag_o   = rst & (req[0] | req[2] | (grant_valid & (grant_q != 2'h1)));

endmodule

// File: tb/tb_bus_arb_ctrl.sv
// tb/tb_bus_arb_ctrl.sv - directed self-checking bench for bus_arb_ctrl
module tb_bus_arb_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_arb_ctrl_if bus_if ();

  bus_arb_ctrl #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic gv, input logic [1:0] g,
                           input logic [2:0] ack, input logic [2:0] err);
    chk({tag, ".gv"},   {2'b0, bus_if.grant_valid_o}, {2'b0, gv});
    chk({tag, ".grant"}, {1'b0, bus_if.grant_o},      {1'b0, g});
    chk({tag, ".ack"},  bus_if.m_ack_o,               ack);
    chk({tag, ".err"},  bus_if.m_err_o,               err);
  endtask

  logic [1:0] exp4 [5];

  initial begin
    checks = 0;
    errors = 0;
    exp4   = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1};
    rst    = 1'b1;
    bus_if.m_req_i = 3'b000;
    bus_if.s_ack_i = 1'b0;

    // T1 reset with all masters requesting
    #1;
    rst = 1'b0;
    bus_if.m_req_i = 3'b111;
    tick();
    chk_state("t1_rst", 1'b0, 2'd1, 3'b000, 3'b000);
    chk("t1_rst.hold", {2'b0, bus_if.hold_flag_o}, 3'd0);
    chk("t1_rst.busy", {2'b0, bus_if.busy_o}, 3'd0);
    rst = 1'b1;
    #1;
    chk("t1_rel.hold", {2'b0, bus_if.hold_flag_o}, 3'd1);
    tick();
    chk_state("t1_grant", 1'b1, 2'd0, 3'b000, 3'b000);
    chk("t1_grant.busy", {2'b0, bus_if.busy_o}, 3'd1);
    bus_if.m_req_i = 3'b000;
    tick();
    chk("t1_idle.gv", {2'b0, bus_if.grant_valid_o}, 3'd0);

    // T2 priority 2 over 1, grant locked until ack
    bus_if.m_req_i = 3'b110;
    #1;
    chk("t2_req.hold", {2'b0, bus_if.hold_flag_o}, 3'd1);
    tick();
    chk_state("t2_c1", 1'b1, 2'd2, 3'b000, 3'b000);
    tick();
    chk_state("t2_c2", 1'b1, 2'd2, 3'b000, 3'b000);
    tick();
    chk_state("t2_c3", 1'b1, 2'd2, 3'b000, 3'b000);
    tick();
    bus_if.s_ack_i = 1'b1;
    #1;
    chk_state("t2_ack", 1'b1, 2'd2, 3'b100, 3'b000);
    tick();
    bus_if.s_ack_i = 1'b0;
    bus_if.m_req_i = 3'b010;
    #1;
    chk_state("t2_m1", 1'b1, 2'd1, 3'b000, 3'b000);
    chk("t2_m1.hold", {2'b0, bus_if.hold_flag_o}, 3'd0);
    bus_if.s_ack_i = 1'b1;
    #1;
    chk("t2_m1ack", bus_if.m_ack_o, 3'b010);
    tick();
    bus_if.s_ack_i = 1'b0;
    bus_if.m_req_i = 3'b000;
    #1;
    chk_state("t2_regrant", 1'b1, 2'd1, 3'b000, 3'b000);
    tick();
    chk("t2_idle.gv", {2'b0, bus_if.grant_valid_o}, 3'd0);

    // T3 back-to-back alternation between m0 and m1
    bus_if.m_req_i = 3'b011;
    bus_if.s_ack_i = 1'b1;
    #1;
    chk("t3_idle.ack", bus_if.m_ack_o, 3'b000);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_state($sformatf("t3_b2b%0d", i), 1'b1, (i % 2 == 0) ? 2'd0 : 2'd1,
                (i % 2 == 0) ? 3'b001 : 3'b010, 3'b000);
      tick();
    end
    bus_if.m_req_i = 3'b000;
    bus_if.s_ack_i = 1'b0;
    tick();
    chk("t3_idle.gv", {2'b0, bus_if.grant_valid_o}, 3'd0);

    // T4 starvation: m0/m2 ping-pong, m1 promoted after 4 denied cycles
    bus_if.m_req_i = 3'b111;
    bus_if.s_ack_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_state($sformatf("t4_c%0d", i), 1'b1, exp4[i], 3'b001 << exp4[i], 3'b000);
      tick();
    end
    bus_if.m_req_i = 3'b000;
    bus_if.s_ack_i = 1'b0;
    tick();
    chk("t4_idle.gv", {2'b0, bus_if.grant_valid_o}, 3'd0);

    // T5 timeout in 8th BUSY cycle, then ack beats timeout
    bus_if.m_req_i = 3'b100;
    tick();
    repeat (6) tick();
    chk_state("t5_c7", 1'b1, 2'd2, 3'b000, 3'b000);
    tick();
    chk_state("t5_tmo", 1'b1, 2'd2, 3'b000, 3'b100);
    tick();
    chk_state("t5_regrant", 1'b1, 2'd2, 3'b000, 3'b000);
    repeat (7) tick();
    bus_if.s_ack_i = 1'b1;
    #1;
    chk_state("t5_ack_vs_tmo", 1'b1, 2'd2, 3'b100, 3'b000);
    tick();
    bus_if.m_req_i = 3'b000;
    bus_if.s_ack_i = 1'b0;
    tick();
    chk("t5_idle.gv", {2'b0, bus_if.grant_valid_o}, 3'd0);

    // T6 request drop before ack, hold flag rule
    bus_if.m_req_i = 3'b001;
    #1;
    chk("t6_req.hold", {2'b0, bus_if.hold_flag_o}, 3'd1);
    tick();
    chk_state("t6_grant", 1'b1, 2'd0, 3'b000, 3'b000);
    bus_if.m_req_i = 3'b000;
    #1;
    chk_state("t6_drop", 1'b1, 2'd0, 3'b000, 3'b000);
    chk("t6_drop.hold", {2'b0, bus_if.hold_flag_o}, 3'd1);
    tick();
    chk_state("t6_idle", 1'b0, 2'd0, 3'b000, 3'b000);
    chk("t6_idle.hold", {2'b0, bus_if.hold_flag_o}, 3'd0);
    bus_if.m_req_i = 3'b010;
    #1;
    chk("t6_m1req.hold", {2'b0, bus_if.hold_flag_o}, 3'd0);
    tick();
    chk_state("t6_m1", 1'b1, 2'd1, 3'b000, 3'b000);
    chk("t6_m1.hold", {2'b0, bus_if.hold_flag_o}, 3'd0);
    bus_if.m_req_i = 3'b000;
    tick();

    // Reset mid-transfer suppresses the pending ack
    bus_if.m_req_i = 3'b001;
    tick();
    bus_if.s_ack_i = 1'b1;
    #1;
    chk("rst_mid.pre_ack", bus_if.m_ack_o, 3'b001);
    rst = 1'b0;
    #1;
    chk_state("rst_mid", 1'b0, 2'd1, 3'b000, 3'b000);
    chk("rst_mid.hold", {2'b0, bus_if.hold_flag_o}, 3'd0);
    rst = 1'b1;
    bus_if.m_req_i = 3'b000;
    bus_if.s_ack_i = 1'b0;
    tick();
    chk("rst_after.gv", {2'b0, bus_if.grant_valid_o}, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
